lif_neuron_n: RTL and testbench
===============================

# lif_neuron_n

Parametrised leaky integrate-and-fire neuron with N_IN weighted synaptic spike inputs, signed saturating membrane arithmetic, runtime threshold, time-step strobe and an absolute refractory period. Drop-in successor to the single-input LIF core. Intended as the per-neuron element replicated under a future layer/array controller.

## Interface
- N_IN, 4: number of synaptic inputs (≥1)
- WW, 8: signed weight width
- VW, 16: signed membrane width
- LEAK, 1: constant leak subtracted per tick (linear mode)
- LEAK_SHIFT, 4: exponential leak shift (LIF_EXP_LEAK_EN mode)
- V_RESET, 0: post-spike membrane value
- V_FLOOR, 0: lower clamp of membrane
- REFRAC_CYC, 2: refractory length in ticks (0 = none)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  time-step strobe; state advances only when high
- in_spk  in  N_IN  input spike bits, sampled at clk edge with en
- weights  in  N_IN*WW  signed weights, input i at [i*WW +: WW]
- v_th  in  VW  signed firing threshold
- spike  out  1  one-cycle spike pulse
- v_mem  out  VW  signed membrane potential
- refrac  out  1  high while in REFRAC

## Operation
- States: INTEG, REFRAC. Reset: state=INTEG, v_mem=V_RESET, spike=0, refrac=0, counter=0.
- syn_sum = Σ in_spk[i] ? weights[i] : 0, signed, width WW+clog2(N_IN)+1.
- leak: linear = LEAK; exponential = (v_mem>0) ? v_mem>>>LEAK_SHIFT : 0.
- v_cand = v_mem − leak + syn_sum, computed at VW+WW+clog2(N_IN)+2 bits, then clamped to [V_FLOOR, 2^(VW−1)−1].
- INTEG, en=1: if v_cand ≥ v_th (signed) → v_mem←V_RESET, spike←1; if REFRAC_CYC>0 → state←REFRAC, counter←REFRAC_CYC, refrac←1. Else v_mem←v_cand, spike←0.
- REFRAC, en=1: in_spk ignored, v_mem held at V_RESET, spike←0, counter−1; when counter==1 → state←INTEG, refrac←0.
- en=0: all state, v_mem, counter held; spike←0.
- Spike with REFRAC_CYC=0: next tick integrates from V_RESET.
- Exponential mode: v_mem < 2^LEAK_SHIFT does not decay (by design).

## Timing
- All outputs registered. in_spk/weights/v_th sampled on the same edge; effect visible on v_mem one cycle later.
- spike high exactly one cycle, on the cycle after the crossing edge, coincident with v_mem=V_RESET.
- Refractory: REFRAC_CYC en-ticks inputs ignored; first integrating tick is tick REFRAC_CYC+1 after the spike.
- rst_n low at any time (including mid-REFRAC) forces reset values immediately; release synchronous to clk.
- Weight/threshold changes take effect on the next en edge; no handshake.

## Configuration
- LIF_EXP_LEAK_EN defined: exponential leak (v_mem>>>LEAK_SHIFT when positive); LEAK unused.
- Undefined: linear leak of LEAK per tick; LEAK_SHIFT unused.

## Structure
- Package lif_pkg: state typedef (INTEG, REFRAC), sum-width/accumulator-width localparam functions, saturating clamp function.
- Sub-module lif_syn_sum: combinational gated-weight adder producing syn_sum; neuron core holds FSM, counter, leak, clamp.

## Test plan
- Reset: rst_n=0 during activity → v_mem=0, spike=0, refrac=0 immediately.
- Linear: weights[0]=5, in_spk=4'b0001 every tick, v_th=50 → v_mem +4/tick, tick 13 v_cand=52 → spike=1 one cycle, v_mem=0, refrac=1 for 2 ticks, inputs ignored.
- Inhibition/floor: v_mem=3, weights[1]=−10, in_spk=4'b0010 → v_mem=0, no spike.
- Saturation: v_mem=32700, all weights=127, all inputs high, v_th=32767 → v_cand clamps to 32767, spike=1.
- Strobe/refractory: en=0 for 5 cycles mid-REFRAC → counter, v_mem, refrac held; spike never asserted; resumes on en.
- LIF_EXP_LEAK_EN: v_mem=160, no inputs, v_th=1000 → 150, then 141, then 133.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron: state encoding, datapath widths
// and the saturating clamp used on the membrane candidate.
package lif_pkg;

  typedef enum logic [0:0] {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_e;

  // Width of the gated-weight sum: one extra bit per doubling of inputs plus sign headroom.
  function automatic int sum_w(input int n_in, input int ww);
    return ww + $clog2(n_in) + 1;
  endfunction

  // Accumulator width for v_mem - leak + syn_sum without wrap.
  function automatic int acc_w(input int n_in, input int ww, input int vw);
    return vw + ww + $clog2(n_in) + 2;
  endfunction

  function automatic longint sat_clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// Combinational synaptic adder: sums the signed weights of all inputs that
// spiked this cycle.
module lif_syn_sum
  import lif_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int WW   = 8,
  parameter int SW   = sum_w(N_IN, WW)
) (
  input  logic [N_IN-1:0]    in_spk,
  input  logic [N_IN*WW-1:0] weights,
  output logic [SW-1:0]      syn_sum
);

  logic signed [SW-1:0] acc;
  logic signed [WW-1:0] w;

  always_comb begin
    acc = '0;
    w   = '0;
    for (int i = 0; i < N_IN; i++) begin
      w = weights[i*WW +: WW];
      if (in_spk[i]) acc = acc + SW'(w);
    end
  end

  assign syn_sum = acc;

endmodule

// File: rtl/lif_neuron_n.sv
// Multi-input leaky integrate-and-fire neuron with saturating membrane and
// absolute refractory period. Define LIF_EXP_LEAK_EN for exponential leak.
module lif_neuron_n
  import lif_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int WW         = 8,
  parameter int VW         = 16,
  parameter int LEAK       = 1,
  parameter int LEAK_SHIFT = 4,
  parameter int V_RESET    = 0,
  parameter int V_FLOOR    = 0,
  parameter int REFRAC_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_IN-1:0]    in_spk,
  input  logic [N_IN*WW-1:0] weights,
  input  logic [VW-1:0]      v_th,
  output logic               spike,
  output logic [VW-1:0]      v_mem,
  output logic               refrac
);

  localparam int     SW    = sum_w(N_IN, WW);
  localparam int     AW    = acc_w(N_IN, WW, VW);
  localparam int     CW    = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
  localparam longint V_MAX = (longint'(1) <<< (VW - 1)) - 1;

  // Elaboration-time guards on parameter ranges.
  if (N_IN < 1) begin : g_bad_n_in
    $error("lif_neuron_n: N_IN must be at least 1");
  end
  if (LEAK < 0 || LEAK_SHIFT < 0 || LEAK_SHIFT >= VW) begin : g_bad_leak
    $error("lif_neuron_n: LEAK must be non-negative and LEAK_SHIFT within [0, VW)");
  end
  if (REFRAC_CYC < 0) begin : g_bad_refrac
    $error("lif_neuron_n: REFRAC_CYC must be non-negative");
  end

  lif_state_e           state;
  logic [CW-1:0]        cnt;
  logic signed [VW-1:0] v_mem_q;
  logic signed [VW-1:0] v_th_s;
  logic signed [SW-1:0] syn_sum;
  logic signed [VW-1:0] leak_v;
  logic signed [AW-1:0] v_cand;
  logic signed [VW-1:0] v_next;
  logic                 fire;

  lif_syn_sum #(
    .N_IN (N_IN),
    .WW   (WW),
    .SW   (SW)
  ) u_syn_sum (
    .in_spk  (in_spk),
    .weights (weights),
    .syn_sum (syn_sum)
  );

  assign v_th_s = v_th;

`ifdef LIF_EXP_LEAK_EN
  // Small positive potentials shift to zero leak, so they never decay.
  assign leak_v = (v_mem_q > 0) ? (v_mem_q >>> LEAK_SHIFT) : '0;
`else
  assign leak_v = VW'(LEAK);
`endif

  assign v_cand = AW'(v_mem_q) - AW'(leak_v) + AW'(syn_sum);
  assign v_next = VW'(sat_clamp(longint'(v_cand), longint'(V_FLOOR), V_MAX));
  assign fire   = (v_next >= v_th_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INTEG;
      cnt     <= '0;
      v_mem_q <= VW'(V_RESET);
      spike   <= 1'b0;
      refrac  <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (en) begin
        case (state)
          INTEG: begin
            if (fire) begin
              v_mem_q <= VW'(V_RESET);
              spike   <= 1'b1;
              if (REFRAC_CYC > 0) begin
                state  <= REFRAC;
                cnt    <= CW'(REFRAC_CYC);
                refrac <= 1'b1;
              end
            end else begin
              v_mem_q <= v_next;
            end
          end
          REFRAC: begin
            v_mem_q <= VW'(V_RESET);
            cnt     <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state  <= INTEG;
              refrac <= 1'b0;
            end
          end
          default: begin
            state  <= INTEG;
            refrac <= 1'b0;
          end
        endcase
      end
    end
  end

  assign v_mem = v_mem_q;

endmodule

// File: tb/tb_lif_neuron_n.sv
// Bench for lif_neuron_n: directed table and hand sequences plus randomized
// stimulus against an integer reference model of the neuron rules.
module tb_lif_neuron_n;

  localparam int N_IN = 4;
  localparam int WW   = 8;
  localparam int VW   = 16;
  localparam int RC   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [N_IN-1:0]      in_spk;
  logic [N_IN*WW-1:0]   weights;
  logic [VW-1:0]        v_th;
  logic                 spike;
  logic [VW-1:0]        v_mem;
  logic                 refrac;

  lif_neuron_n #(
    .N_IN(N_IN), .WW(WW), .VW(VW), .LEAK(1), .LEAK_SHIFT(4),
    .V_RESET(0), .V_FLOOR(0), .REFRAC_CYC(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spk(in_spk), .weights(weights),
    .v_th(v_th), .spike(spike), .v_mem(v_mem), .refrac(refrac)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: membrane value, remaining refractory ticks, last spike.
  int   m_v;
  int   m_left;
  logic m_spk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_left = 0; m_spk = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] s, input logic [31:0] w, input int vth);
    int sum, lk, cand;
    logic signed [7:0] wi;
    m_spk = 1'b0;
    if (!e) return;
    if (m_left > 0) begin
      m_left--;
      m_v = 0;
      return;
    end
    sum = 0;
    for (int i = 0; i < N_IN; i++) begin
      wi = w[i*8 +: 8];
      if (s[i]) sum += int'(wi);
    end
`ifdef LIF_EXP_LEAK_EN
    lk = (m_v > 0) ? (m_v / 16) : 0;
`else
    lk = 1;
`endif
    cand = m_v - lk + sum;
    if (cand < 0) cand = 0;
    if (cand > 32767) cand = 32767;
    if (cand >= vth) begin
      m_v = 0; m_spk = 1'b1; m_left = RC;
    end else begin
      m_v = cand;
    end
  endtask

  task automatic tick(input logic e, input logic [3:0] s, input logic [31:0] w, input int vth);
    @(negedge clk);
    en = e; in_spk = s; weights = w; v_th = vth[15:0];
    @(posedge clk);
    model_step(e, s, w, vth);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; in_spk = '0; weights = '0; v_th = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input int ev, input int es, input int er);
    chk({name, "_v"}, int'($signed(v_mem)), ev);
    chk({name, "_spike"}, int'(spike), es);
    chk({name, "_refrac"}, int'(refrac), er);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  spk;
    logic [31:0] w;
    int          vth;
    int          ev;
    logic        es;
    logic        er;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; en = 1'b0; in_spk = '0; weights = '0; v_th = '0;
    model_reset();
    #1;
    chk_out("reset", 0, 0, 0);
    do_reset();

`ifdef LIF_EXP_LEAK_EN
    // Exponential decay from 160 with no input.
    tick(1'b1, 4'b0001, 32'd100, 1000); chk_out("exp_ramp1", 100, 0, 0);
    tick(1'b1, 4'b0001, 32'd66, 1000);  chk_out("exp_ramp2", 160, 0, 0);
    tick(1'b1, 4'b0000, 32'd0, 1000);   chk_out("exp_d1", 150, 0, 0);
    tick(1'b1, 4'b0000, 32'd0, 1000);   chk_out("exp_d2", 141, 0, 0);
    tick(1'b1, 4'b0000, 32'd0, 1000);   chk_out("exp_d3", 133, 0, 0);
`else
    // Linear ramp to threshold, spike, refractory, resume.
    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 4'b0001, 32'h5, 50, 4 * (i + 1), 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0001, 32'h5, 50, 0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 4'b0001, 32'h5, 50, 0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 4'b0001, 32'h5, 50, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'b0001, 32'h5, 50, 4, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].en, tbl[i].spk, tbl[i].w, tbl[i].vth);
      chk_out($sformatf("lin%0d", i), tbl[i].ev, int'(tbl[i].es), int'(tbl[i].er));
    end

    // Inhibition clamps at the floor.
    do_reset();
    tick(1'b1, 4'b0001, 32'h0000_0004, 1000); chk_out("inh_pre", 3, 0, 0);
    tick(1'b1, 4'b0010, 32'h0000_F600, 1000); chk_out("inh_floor", 0, 0, 0);
    tick(1'b1, 4'b0010, 32'h0000_F600, 1000); chk_out("inh_floor2", 0, 0, 0);

    // Saturation near the top of the range must not wrap negative.
    do_reset();
    for (int i = 0; i < 64; i++) tick(1'b1, 4'b1111, 32'h7F7F_7F7F, 32767);
    chk_out("sat_pre", 32448, 0, 0);
    tick(1'b1, 4'b1111, 32'h7F7F_7F7F, 32767); chk_out("sat_fire", 0, 1, 1);

    // Asynchronous reset mid-refractory.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("async_rst", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Strobe held low during refractory.
    tick(1'b1, 4'b0001, 32'h0000_003C, 50); chk_out("stb_fire", 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'b1111, 32'h7F7F_7F7F, 0);
      chk_out($sformatf("stb_hold%0d", i), 0, 0, 1);
    end
    tick(1'b1, 4'b1111, 32'h7F7F_7F7F, 0);  chk_out("stb_r1", 0, 0, 1);
    tick(1'b1, 4'b1111, 32'h7F7F_7F7F, 0);  chk_out("stb_r2", 0, 0, 0);
    tick(1'b1, 4'b0001, 32'h0000_003C, 50); chk_out("stb_refire", 0, 1, 1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        e;
      logic [3:0]  s;
      logic [31:0] w;
      int          vth;
      e   = ($urandom_range(0, 9) < 8);
      s   = 4'($urandom);
      w   = $urandom;
      if ($urandom_range(0, 1) == 1) w = w & 32'h7F7F_7F7F;
      vth = int'($urandom_range(0, 420)) - 20;
      tick(e, s, w, vth);
      chk("rnd_v", int'($signed(v_mem)), m_v);
      chk("rnd_spike", int'(spike), int'(m_spk));
      chk("rnd_refrac", int'(refrac), (m_left > 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
